// File: rtl/seg_capture.sv
// Seven-segment display snooper: watches the multiplexed segment/digit-enable
// lines of a 4-digit display, waits for each digit to settle, decodes it to a
// hex nibble and publishes the full 16-bit frame once all four digits are seen.
module seg_capture #(
   parameter int unsigned STABLE_CYC = 4,
   parameter int unsigned TIMEOUT    = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  seg_n,
   input  logic [3:0]  an_n,
   output logic [15:0] value,
   output logic        valid,
   output logic        err
);

   typedef enum logic {StIdle, StCollect} state_t;

   // Sampling / stability tracking
   logic [10:0] s_q;
   logic [7:0]  cnt_q;

   // Frame assembly state
   state_t      state_q;
   logic [3:0]  mask_q;
   logic        ferr_q;
   logic [15:0] idle_q;
   logic [15:0] dig_q;
   logic [15:0] value_q;
   logic        valid_q;
   logic        err_q;

   // Combinational helpers
   logic [10:0] samp;
   logic        same;
   logic        stable_hit;
   logic        sel_ok;
   logic [1:0]  sel_idx;
   logic [3:0]  sel_bit;
   logic        capture;
   logic        unrec;
   logic [3:0]  nib;
   logic [3:0]  mask_new;
   logic [15:0] dig_new;

   // Active-high abcdefg pattern to {unrecognised, nibble}
   function automatic logic [4:0] decode_seg(input logic [6:0] p);
      logic [4:0] r;
      case (p)
         7'h7E:   r = 5'h00;
         7'h30:   r = 5'h01;
         7'h6D:   r = 5'h02;
         7'h79:   r = 5'h03;
         7'h33:   r = 5'h04;
         7'h5B:   r = 5'h05;
         7'h5F:   r = 5'h06;
         7'h70:   r = 5'h07;
         7'h7F:   r = 5'h08;
         7'h7B:   r = 5'h09;
         7'h77:   r = 5'h0A;
         7'h1F:   r = 5'h0B;
         7'h4E:   r = 5'h0C;
         7'h3D:   r = 5'h0D;
         7'h4F:   r = 5'h0E;
         7'h47:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

   // Capture strobe, digit select, decode and merged digit image
   always_comb begin
      samp       = {an_n, seg_n};
      same       = (samp == s_q);
      stable_hit = same && (cnt_q == 8'(STABLE_CYC - 1));

      sel_ok  = 1'b1;
      sel_idx = 2'd0;
      case (an_n)
         4'b1110: sel_idx = 2'd0;
         4'b1101: sel_idx = 2'd1;
         4'b1011: sel_idx = 2'd2;
         4'b0111: sel_idx = 2'd3;
         default: sel_ok  = 1'b0;
      endcase
      sel_bit = 4'b0001 << sel_idx;

      {unrec, nib} = decode_seg(~seg_n);
      capture      = stable_hit && sel_ok;

      mask_new = mask_q | sel_bit;
      dig_new  = dig_q;
      dig_new[{sel_idx, 2'b00} +: 4] = nib;
   end

   // Input sampling and saturating stability counter
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q   <= '1;
         cnt_q <= '0;
      end else begin
         s_q <= samp;
         if (!same) begin
            cnt_q <= '0;
         end else if (cnt_q != 8'(STABLE_CYC)) begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

   // Frame FSM: collect four digits in any order, publish or time out
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         mask_q  <= '0;
         ferr_q  <= 1'b0;
         idle_q  <= '0;
         dig_q   <= '0;
         value_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (capture) begin
                  dig_q   <= dig_new;
                  mask_q  <= sel_bit;
                  ferr_q  <= unrec;
                  idle_q  <= '0;
                  state_q <= StCollect;
               end
            end
            StCollect: begin
               if (capture) begin
                  // Capture beats a coincident timeout
                  idle_q <= '0;
                  dig_q  <= dig_new;
                  if (mask_new == 4'hF) begin
                     value_q <= dig_new;
                     valid_q <= 1'b1;
                     err_q   <= ferr_q | unrec;
                     mask_q  <= '0;
                     ferr_q  <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     mask_q <= mask_new;
                     ferr_q <= ferr_q | unrec;
                  end
               end else if (idle_q == 16'(TIMEOUT)) begin
                  mask_q  <= '0;
                  ferr_q  <= 1'b0;
                  idle_q  <= '0;
                  state_q <= StIdle;
               end else begin
                  idle_q <= idle_q + 16'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign value = value_q;
   assign valid = valid_q;
   assign err   = err_q;

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: directed scenarios plus randomized display traffic,
// all checked against a cycle-level behavioural model of the frame rules.
module tb_seg_capture;

   localparam int unsigned STABLE = 4;
   localparam int unsigned TMO    = 40;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_n;
   logic [3:0]  an_n;
   logic [15:0] value;
   logic        valid;
   logic        err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seg_capture #(
      .STABLE_CYC (STABLE),
      .TIMEOUT    (TMO)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .seg_n (seg_n),
      .an_n  (an_n),
      .value (value),
      .valid (valid),
      .err   (err)
   );

   // Active-high abcdefg pattern for hex digits 0..F
   logic [6:0] pat_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   function automatic logic [6:0] enc(input int d);
      logic [6:0] p;
      p = pat_tab[d];
      return ~p;
   endfunction

   function automatic void ref_decode(input logic [6:0] p, output logic [3:0] n,
                                      output logic bad);
      n   = 4'h0;
      bad = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (pat_tab[i] == p) begin
            n   = 4'(i);
            bad = 1'b0;
         end
      end
   endfunction

   // ---------------- reference model ----------------
   logic [10:0] m_prev;
   int          m_run;
   logic [3:0]  m_mask;
   logic [3:0]  m_dig [4];
   logic        m_ferr;
   int          m_gap;
   logic [15:0] m_value;
   logic        m_valid;
   logic        m_err;
   int          m_pulses = 0;
   int          d_pulses = 0;

   always @(posedge clk) begin : model
      logic [10:0] cur;
      int          k;
      logic [3:0]  nb;
      logic        bad;
      if (rst) begin
         m_prev  = '1;
         m_run   = 1;
         m_mask  = '0;
         m_ferr  = 1'b0;
         m_gap   = 0;
         m_value = '0;
         m_valid = 1'b0;
         m_err   = 1'b0;
      end else begin
         cur = {an_n, seg_n};
         if (cur == m_prev) begin
            if (m_run < 100000) m_run++;
         end else begin
            m_run = 1;
         end
         m_prev  = cur;
         m_valid = 1'b0;
         k = -1;
         for (int i = 0; i < 4; i++)
            if (an_n == (4'b1111 ^ (4'b0001 << i))) k = i;
         // A sample held STABLE+1 cycles in a row is taken on that last cycle
         if (m_run == STABLE + 1 && k >= 0) begin
            ref_decode(~seg_n, nb, bad);
            m_dig[k]  = nb;
            m_mask[k] = 1'b1;
            m_ferr    = m_ferr | bad;
            m_gap     = 0;
            if (m_mask == 4'hF) begin
               m_value = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
               m_valid = 1'b1;
               m_err   = m_ferr;
               m_mask  = '0;
               m_ferr  = 1'b0;
               m_pulses++;
            end
         end else if (m_mask != 0) begin
            m_gap++;
            if (m_gap > TMO) begin
               m_mask = '0;
               m_ferr = 1'b0;
               m_gap  = 0;
            end
         end
      end
   end

   // Count DUT valid pulses shortly after each edge
   always @(posedge clk) begin
      #1;
      if (valid === 1'b1) d_pulses++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
      an_n  = a;
      seg_n = s;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      an_n  = '1;
      seg_n = '1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] v);
      hold(4'b1110, enc(int'(v[3:0])), 8);
      hold(4'b1101, enc(int'(v[7:4])), 8);
      hold(4'b1011, enc(int'(v[11:8])), 8);
      hold(4'b0111, enc(int'(v[15:12])), 8);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst   = 1'b1;
      an_n  = 4'b1110;
      seg_n = enc(5);
      repeat (3) @(negedge clk);
      n_vec++;
      if (value !== 16'h0 || valid !== 1'b0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL reset: value=%h valid=%b err=%b, want 0000/0/0", value, valid, err);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int p0;
      do_reset();
      p0 = d_pulses;
      send_frame(16'h1234);
      n_vec++;
      if (d_pulses - p0 !== 1) begin
         n_err++;
         $display("FAIL basic_pulses: got %0d, want 1", d_pulses - p0);
      end
      n_vec++;
      if (value !== 16'h1234 || err !== 1'b0 || valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic_value: value=%h err=%b valid=%b, want 1234/0/0", value, err, valid);
      end
   endtask

   task automatic test_stability();
      int p0;
      do_reset();
      p0 = d_pulses;
      hold(4'b1110, enc(5), 4);
      hold(4'b1101, enc(6), 8);
      hold(4'b1011, enc(7), 8);
      hold(4'b0111, enc(8), 8);
      n_vec++;
      if (d_pulses - p0 !== 0) begin
         n_err++;
         $display("FAIL stab_4cyc: got %0d pulses, want 0", d_pulses - p0);
      end
      hold(4'b1110, enc(9), 4);
      n_vec++;
      if (valid !== 1'b0) begin
         n_err++;
         $display("FAIL stab_early: valid=%b after 4 cycles, want 0", valid);
      end
      @(negedge clk);
      n_vec++;
      if (valid !== 1'b1 || value !== 16'h8769) begin
         n_err++;
         $display("FAIL stab_5th: valid=%b value=%h, want 1/8769", valid, value);
      end
      hold(4'b1111, 7'h7F, 4);
   endtask

   task automatic test_bad_pattern();
      int p0;
      do_reset();
      p0 = d_pulses;
      hold(4'b1110, enc(4), 8);
      hold(4'b1101, enc(3), 8);
      hold(4'b1011, 7'h7F, 8);
      hold(4'b0111, enc(1), 8);
      n_vec++;
      if (d_pulses - p0 !== 1 || value !== 16'h1034 || err !== 1'b1) begin
         n_err++;
         $display("FAIL bad_pattern: pulses=%0d value=%h err=%b, want 1/1034/1",
                  d_pulses - p0, value, err);
      end
   endtask

   task automatic test_multi_enable();
      int p0;
      do_reset();
      p0 = d_pulses;
      hold(4'b1110, enc(4), 8);
      hold(4'b1101, enc(3), 8);
      hold(4'b1011, enc(2), 8);
      an_n  = 4'b1100;
      seg_n = enc(7);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_vec++;
         if (valid !== 1'b0) begin
            n_err++;
            $display("FAIL multi_en: valid=%b at cycle %0d, want 0", valid, i);
         end
      end
      hold(4'b0111, enc(1), 8);
      n_vec++;
      if (d_pulses - p0 !== 1 || value !== 16'h1234) begin
         n_err++;
         $display("FAIL multi_en_mask: pulses=%0d value=%h, want 1/1234", d_pulses - p0, value);
      end
   endtask

   task automatic test_timeout();
      int p0;
      do_reset();
      p0 = d_pulses;
      hold(4'b1110, enc(5), 8);
      hold(4'b1101, enc(6), 8);
      hold(4'b1111, 7'h7F, TMO + 5);
      hold(4'b1011, enc(7), 8);
      hold(4'b0111, enc(8), 8);
      n_vec++;
      if (d_pulses - p0 !== 0) begin
         n_err++;
         $display("FAIL timeout_discard: got %0d pulses, want 0", d_pulses - p0);
      end
      hold(4'b1111, 7'h7F, TMO + 5);
      send_frame(16'hABCD);
      n_vec++;
      if (d_pulses - p0 !== 1 || value !== 16'hABCD || err !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_fresh: pulses=%0d value=%h err=%b, want 1/abcd/0",
                  d_pulses - p0, value, err);
      end
   endtask

   // Last digit lands exactly when the idle count hits TIMEOUT, then one cycle late
   task automatic test_timeout_edge();
      int p0;
      for (int late = 0; late < 2; late++) begin
         do_reset();
         p0 = d_pulses;
         hold(4'b1110, enc(1), 8);
         hold(4'b1101, enc(2), 8);
         hold(4'b1011, enc(3), 8);
         hold(4'b1111, 7'h7F, TMO - 7 + late);
         hold(4'b0111, enc(4), 8);
         n_vec++;
         if (d_pulses - p0 !== 1 - late || d_pulses - p0 !== m_pulses - p0) begin
            n_err++;
            $display("FAIL timeout_edge late=%0d: pulses=%0d, want %0d",
                     late, d_pulses - p0, 1 - late);
         end
         if (late == 0) begin
            n_vec++;
            if (value !== 16'h4321) begin
               n_err++;
               $display("FAIL timeout_edge_value: value=%h, want 4321", value);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      do_reset();
      hold(4'b1110, enc(4), 8);
      hold(4'b1101, enc(3), 8);
      hold(4'b1011, 7'h00, 8);
      hold(4'b0111, enc(1), 8);
      hold(4'b1110, enc(9), 8);
      hold(4'b1101, enc(9), 8);
      hold(4'b1011, enc(9), 8);
      rst   = 1'b1;
      an_n  = '1;
      seg_n = '1;
      @(negedge clk);
      rst = 1'b0;
      n_vec++;
      if (value !== 16'h0 || valid !== 1'b0 || err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_out: value=%h valid=%b err=%b, want 0000/0/0",
                  value, valid, err);
      end
      p0 = d_pulses;
      hold(4'b0111, enc(9), 8);
      hold(4'b1111, 7'h7F, 4);
      n_vec++;
      if (d_pulses - p0 !== 0 || value !== 16'h0) begin
         n_err++;
         $display("FAIL reset_mid_stale: pulses=%0d value=%h, want 0/0000",
                  d_pulses - p0, value);
      end
   endtask

   task automatic test_random();
      int          p0;
      int          len;
      logic [3:0]  a;
      logic [6:0]  s;
      do_reset();
      p0 = d_pulses;
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 19) == 0) begin
            a   = 4'b1111;
            s   = 7'h7F;
            len = int'($urandom_range(TMO - 6, TMO + 6));
         end else begin
            if ($urandom_range(0, 9) == 0) a = 4'($urandom);
            else a = 4'b1111 ^ (4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) s = 7'($urandom);
            else s = enc(int'($urandom_range(0, 15)));
            len = int'($urandom_range(1, 9));
         end
         an_n  = a;
         seg_n = s;
         for (int c = 0; c < len; c++) begin
            @(negedge clk);
            n_vec++;
            if (valid !== m_valid || value !== m_value || err !== m_err) begin
               n_err++;
               $display("FAIL random it=%0d: valid=%b value=%h err=%b, want %b/%h/%b",
                        it, valid, value, err, m_valid, m_value, m_err);
            end
         end
      end
      n_vec++;
      if (d_pulses - p0 !== m_pulses - p0) begin
         n_err++;
         $display("FAIL random_pulses: got %0d, want %0d", d_pulses - p0, m_pulses - p0);
      end
   endtask

   initial begin
      rst   = 1'b1;
      an_n  = '1;
      seg_n = '1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_stability();
      test_bad_pattern();
      test_multi_enable();
      test_timeout();
      test_timeout_edge();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seg_capture.md
SEG_CAPTURE -- requirements
Module: seg_capture

Interface
REQ-001 Parameter STABLE_CYC, default 4, SHALL set the consecutive-cycle count a segment/digit-enable sample must hold before capture (range 2..255).
REQ-002 Parameter TIMEOUT, default 1000, SHALL set the idle cycles after the last capture before a partial frame is discarded (range 16..65535).
REQ-003 clk  input  1  rising-edge system clock; one clock, synchronous reset.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 seg_n  input  7  active-low segments; seg_n[6]=a, seg_n[5]=b, ... seg_n[0]=g.
REQ-006 an_n  input  4  active-low digit enables; an_n[k] low selects digit k.
REQ-007 value  output  16  last complete frame; digit k in value[4k+3:4k].
REQ-008 valid  output  1  one-cycle pulse: value and err updated.
REQ-009 err  output  1  frame contained an unrecognised pattern; meaningful while valid=1, held until next frame.

Function
REQ-010 The block SHALL map an active-high pattern p = ~seg_n (abcdefg, a=MSB) to a nibble as follows: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 4F->E, 47->F; any other p SHALL map to nibble 0 and be flagged unrecognised.
REQ-011 The block SHALL register sample s_q = {an_n, seg_n} every cycle.
REQ-012 A stability counter cnt SHALL clear to 0 when {an_n, seg_n} != s_q, otherwise increment, saturating at STABLE_CYC.
REQ-013 A capture strobe SHALL fire in the cycle where {an_n, seg_n} == s_q and cnt == STABLE_CYC-1; a constant input therefore captures once, STABLE_CYC cycles after its first cycle, and never again until it changes.
REQ-014 The capture strobe SHALL be suppressed unless exactly one bit of an_n is 0.
REQ-015 On capture of digit k, the block SHALL write the decoded nibble into digit register k, set mask[k], and OR the unrecognised flag into the frame error bit.
REQ-016 Re-capture of an already-captured digit within a frame SHALL overwrite its nibble; its unrecognised flag SHALL still be ORed into the frame error bit, and it SHALL raise no separate fault.
REQ-017 Capture order SHALL be free; the frame completes when the mask including the current capture equals 4'b1111.
REQ-018 At the clock edge ending the completing capture cycle, the block SHALL load value with all four digit registers (including the new nibble), set valid=1 and err=frame error, and clear the mask and frame error bit.
REQ-019 valid SHALL be high exactly one cycle per completed frame; value and err SHALL hold until the next completion.
REQ-020 The state machine SHALL have two states: IDLE (mask==0) and COLLECT (mask!=0).
REQ-021 IDLE->COLLECT SHALL occur on any capture; COLLECT->IDLE SHALL occur on frame completion or timeout.
REQ-022 A 16-bit idle counter SHALL run only in COLLECT and SHALL clear on each capture.
REQ-023 When the idle counter reaches TIMEOUT, the block SHALL clear the mask and frame error bit without pulsing valid; value and err SHALL be unchanged.
REQ-024 Capture and timeout in the same cycle: capture SHALL take priority and the idle counter SHALL clear.

Reset
REQ-025 While rst=1 at a rising edge, value SHALL be 0, valid 0, err 0, mask 0, frame error 0, cnt 0, idle counter 0, and s_q all ones.
REQ-026 Reset mid-frame SHALL discard all partial digits; no valid pulse SHALL follow until four fresh captures after rst deasserts.

Verification
REQ-027 STABLE_CYC=4; hold an_n=1110/seg_n=~33, 1101/~79, 1011/~6D, 0111/~30, 8 cycles each -> single valid pulse, value=16'h1234, err=0.
REQ-028 Hold a digit pattern for 4 cycles, then change it -> no capture; a pattern held 5 cycles captures (strobe on 5th cycle).
REQ-029 Digit 2 driven with seg_n=7'h7F (blank), other digits valid as in REQ-027 -> valid, value=16'h1034, err=1.
REQ-030 an_n=1100 held 20 cycles -> no capture, mask unchanged, valid stays 0.
REQ-031 Capture digits 0 and 1, then idle for TIMEOUT+5 cycles, then send all four digits of 16'hABCD -> exactly one valid, value=16'hABCD; no stale nibbles.
REQ-032 Capture 3 digits, pulse rst for 1 cycle, then capture only digit 3 -> no valid; all outputs 0 after reset.
